f1_window_reader: RTL and testbench
===================================

Name: f1_window_reader

Overview:
- Read-side engine for the conv-layer-1 feature RAM.
- Walks the 32x32 8-bit feature map stored in the feature RAM and issues read addresses in sliding-window order: 5x5 kernel, stride 1, 28x28 output positions.
- Absorbs the RAM's fixed 2-cycle read latency and delivers a valid/ready pixel stream, tagged with window-first/last flags, to the conv1 MAC datapath.

Parameters:
- IMG_W, 32, feature map width in pixels
- IMG_H, 32, feature map height in pixels
- K, 5, kernel size (square window, stride 1)
- AW, 10, read address width (must satisfy 2^AW >= IMG_W*IMG_H)
- DW, 8, pixel width
- RD_LAT, 2, RAM read latency in cycles (address to data)
- FIFO_D, 4, output skid FIFO depth (must be >= RD_LAT+1)

Ports:
- clk  in  1  single clock; also drives the RAM read port
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- f1_raddr  out  AW  RAM read address
- f1_rdata  in  DW  RAM read data; valid RD_LAT cycles after the address
- pix_data  out  DW  window pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  consumer accepts the pixel this cycle
- pix_first  out  1  pixel is (ky=0,kx=0) of a window
- pix_last  out  1  pixel is (ky=K-1,kx=K-1) of a window
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset (async, rst_n=0): all outputs 0 (f1_raddr=0, pix_valid=0, busy=0, frame_done=0). Counters, FIFO and in-flight pipe are cleared. Reset mid-frame discards all outstanding reads; no pixel is emitted after release until a new start.
- Ordering: nested loops oy 0..IMG_H-K, ox 0..IMG_W-K, ky 0..K-1, kx 0..K-1 (kx innermost).
  - f1_raddr = (oy+ky)*IMG_W + (ox+kx), computed with AW-bit unsigned arithmetic.
  - Use row-base accumulation; no multiplier is required.
  - Total reads per frame = 28*28*25 = 19600.
- FSM:
  - IDLE: on start, go to RUN and set busy=1.
  - RUN: issue reads under credit. After the last address is issued, go to DRAIN.
  - DRAIN: wait until the in-flight pipe and FIFO are empty and the last pixel has been accepted, then go to DONE.
  - DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
- start while not IDLE is ignored.
- Read issue: the RAM has no read enable, so an issue is an internal "issue" cycle that presents the new address.
  - Issue shifts a 1 into an RD_LAT-deep valid pipe; a non-issue cycle shifts in a 0. The first/last tags travel alongside.
  - When the pipe output is 1, f1_rdata and its tags are written into the FIFO.
  - f1_raddr holds its last value on non-issue cycles.
- Credit rule: issue only if (fifo_count + inflight - pop) < FIFO_D, where pop = pix_valid & pix_ready in this cycle. The FIFO never overflows.
- Throughput: with pix_ready held high, one pixel per cycle after an initial latency of RD_LAT+1 cycles (start to first pix_valid = 3 cycles at defaults).
- Output: pix_valid = FIFO non-empty. pix_data/pix_first/pix_last are stable while pix_valid & !pix_ready.
- Simultaneous FIFO push and pop is allowed; the count is unchanged.
- frame_done is asserted the cycle after the handshake of the pixel with oy=ox=IMG_H-K and pix_last=1.

Decomposition:
- Shared package (conv1 pkg) holds:
  - constants IMG_W, IMG_H, K, AW, DW, RD_LAT
  - derived OUT_W = IMG_W-K+1 and OUT_H = IMG_H-K+1
  - FSM state encoding: IDLE, RUN, DRAIN, DONE
- One sub-module, f1_skid_fifo: synchronous FIFO of width DW+2, depth FIFO_D, exposing count/full/empty. It is reused by later layer readers.

Test Plan:
- Reset, then start with pix_ready=1:
  - first 25 addresses are 0,1,2,3,4,32,...,36,...,128..132
  - pix_first on pixel 1, pix_last on pixel 25
  - first pix_valid 3 cycles after start
- Window stepping:
  - window 2 (oy=0,ox=1) first address = 1
  - window 29 (oy=1,ox=0) first address = 32
  - final window's last address = 1023
  - exactly 19600 pixels, then frame_done pulse; busy drops the same cycle
- Data integrity with RAM model preloaded mem[a]=a[7:0]: every pix_data equals the low 8 bits of its computed address.
- Backpressure:
  - pix_ready toggles 0/1 randomly and is held 0 for 10 cycles: no pixel is lost or duplicated, output is held stable, FIFO count never exceeds 4, pixel count remains 19600.
  - pix_ready=1 constantly: one pixel per cycle.
- start pulsed again at pixel 500: ignored; sequence and count are unchanged.
- rst_n asserted at pixel 1000 for 1 cycle: outputs drop to 0 asynchronously; no pix_valid until the next start; the following frame restarts at address 0.

Source files
------------

// File: rtl/f1_window_reader_pkg.sv
// Shared constants, derived sizes and FSM encoding for the conv1 feature-RAM readers.
package f1_window_reader_pkg;

    localparam int unsigned IMG_W  = 32;
    localparam int unsigned IMG_H  = 32;
    localparam int unsigned K      = 5;
    localparam int unsigned AW     = 10;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned FIFO_D = 4;

    localparam int unsigned OUT_W = IMG_W - K + 1;
    localparam int unsigned OUT_H = IMG_H - K + 1;

    localparam int unsigned OXW = $clog2(OUT_W + 1);
    localparam int unsigned OYW = $clog2(OUT_H + 1);
    localparam int unsigned KW  = $clog2(K);
    localparam int unsigned CW  = $clog2(FIFO_D + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    function automatic logic [CW-1:0] count_ones(input logic [RD_LAT-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            n = n + {{(CW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/f1_window_reader_skid_fifo.sv
// f1_skid_fifo: small synchronous FIFO with occupancy outputs, shared by the layer readers.
module f1_skid_fifo #(
    parameter int unsigned Width = 10,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           wdata_i,
    output logic [Width-1:0]           rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned FW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == FW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/f1_window_reader.sv
// Sliding-window read engine for the conv1 feature RAM: issues 5x5/stride-1 window addresses
// under FIFO credit, absorbs the RAM read latency and streams tagged pixels to the MAC datapath.
module f1_window_reader
    import f1_window_reader_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] f1_raddr,
    input  logic [DW-1:0] f1_rdata,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_first,
    output logic          pix_last,
    output logic          busy,
    output logic          frame_done
);

    logic [1:0]        state_q, state_d;
    logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
    logic [OXW-1:0]    ox_q, ox_d;
    logic [OYW-1:0]    oy_q, oy_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     row_q, row_d;
    logic [AW-1:0]     win_q, win_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic [RD_LAT-1:0] fpipe_q, fpipe_d;
    logic [RD_LAT-1:0] lpipe_q, lpipe_d;

    logic [DW+1:0]     fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic              pop, push, issue, at_end, drained;
    logic [CW-1:0]     inflight;
    logic [CW:0]       occ;

    assign pop      = pix_valid && pix_ready;
    assign push     = vpipe_q[RD_LAT-1];
    assign inflight = count_ones(vpipe_q);

    // Occupancy counts reads still in the RAM pipe, so the FIFO can absorb every one of them.
    assign occ   = {1'b0, fifo_count} + {1'b0, inflight} - {{CW{1'b0}}, pop};
    assign issue = (state_q == StRun) && (occ < (CW+1)'(FIFO_D)) && !(fifo_full && !pop);

    assign at_end = (oy_q == OYW'(OUT_H - 1)) && (ox_q == OXW'(OUT_W - 1)) &&
                    (ky_q == KW'(K - 1)) && (kx_q == KW'(K - 1));

    assign drained = (vpipe_q == '0) &&
                     (fifo_empty || ((fifo_count == CW'(1)) && pop));

    assign f1_raddr = issue ? addr_q : raddr_q;
    assign raddr_d  = f1_raddr;

    always_comb begin
        kx_d   = kx_q;
        ky_d   = ky_q;
        ox_d   = ox_q;
        oy_d   = oy_q;
        addr_d = addr_q;
        row_d  = row_q;
        win_d  = win_q;
        if ((state_q == StIdle) && start) begin
            kx_d   = '0;
            ky_d   = '0;
            ox_d   = '0;
            oy_d   = '0;
            addr_d = '0;
            row_d  = '0;
            win_d  = '0;
        end else if (issue) begin
            if (kx_q != KW'(K - 1)) begin
                kx_d   = kx_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end else begin
                kx_d = '0;
                if (ky_q != KW'(K - 1)) begin
                    ky_d   = ky_q + 1'b1;
                    row_d  = row_q + AW'(IMG_W);
                    addr_d = row_q + AW'(IMG_W);
                end else begin
                    ky_d = '0;
                    if (ox_q != OXW'(OUT_W - 1)) begin
                        ox_d  = ox_q + 1'b1;
                        win_d = win_q + 1'b1;
                    end else begin
                        // End of an output row: jump from (oy, OUT_W-1) to (oy+1, 0).
                        ox_d  = '0;
                        oy_d  = oy_q + 1'b1;
                        win_d = win_q + AW'(K);
                    end
                    row_d  = win_d;
                    addr_d = win_d;
                end
            end
        end
    end

    always_comb begin
        vpipe_d = {vpipe_q[RD_LAT-2:0], issue};
        fpipe_d = {fpipe_q[RD_LAT-2:0], (kx_q == '0) && (ky_q == '0)};
        lpipe_d = {lpipe_q[RD_LAT-2:0], (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1))};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (issue && at_end) state_d = StDrain;
            StDrain: if (drained) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            kx_q    <= '0;
            ky_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            win_q   <= '0;
            raddr_q <= '0;
            vpipe_q <= '0;
            fpipe_q <= '0;
            lpipe_q <= '0;
        end else begin
            state_q <= state_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            win_q   <= win_d;
            raddr_q <= raddr_d;
            vpipe_q <= vpipe_d;
            fpipe_q <= fpipe_d;
            lpipe_q <= lpipe_d;
        end
    end

    f1_skid_fifo #(
        .Width(DW + 2),
        .Depth(FIFO_D)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i({fpipe_q[RD_LAT-1], lpipe_q[RD_LAT-1], f1_rdata}),
        .rdata_o(fifo_rdata),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign pix_valid  = !fifo_empty;
    assign pix_data   = pix_valid ? fifo_rdata[DW-1:0] : '0;
    assign pix_first  = pix_valid && fifo_rdata[DW+1];
    assign pix_last   = pix_valid && fifo_rdata[DW];
    assign busy       = (state_q == StRun) || (state_q == StDrain);
    assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_f1_window_reader.sv
// Scoreboard bench for f1_window_reader: a loop model of the window order feeds expected
// address and pixel queues; a negedge monitor pops and compares as the DUT presents them.
module tb_f1_window_reader;
    import f1_window_reader_pkg::*;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          first;
        logic          last;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic [AW-1:0] f1_raddr;
    logic [DW-1:0] f1_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid, pix_first, pix_last, busy, frame_done;

    always #5 clk = ~clk;

    f1_window_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .f1_raddr  (f1_raddr),
        .f1_rdata  (f1_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_first (pix_first),
        .pix_last  (pix_last),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // RAM model: address registered, data two cycles after the address is presented.
    logic [DW-1:0] mem [1 << AW];
    logic [DW-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[f1_raddr];
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign f1_rdata = rd_pipe[RD_LAT-1];

    pix_t          exp_pix_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            errors = 0;
    int            checks = 0;
    int            pix_cnt = 0;
    int            cyc = 0;
    int            first_hs = 0;
    int            last_hs = 0;
    int            fifo_max = 0;
    int            ready_mode = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic build_frame();
        pix_t p;
        exp_pix_q.delete();
        exp_addr_q.delete();
        for (int oy = 0; oy < int'(OUT_H); oy++)
            for (int ox = 0; ox < int'(OUT_W); ox++)
                for (int ky = 0; ky < int'(K); ky++)
                    for (int kx = 0; kx < int'(K); kx++) begin
                        p.addr  = AW'((oy + ky) * int'(IMG_W) + ox + kx);
                        p.first = (ky == 0) && (kx == 0);
                        p.last  = (ky == int'(K) - 1) && (kx == int'(K) - 1);
                        exp_pix_q.push_back(p);
                        exp_addr_q.push_back(p.addr);
                    end
        // A first address equal to the held one produces no visible change on the bus.
        if (f1_raddr == exp_addr_q[0]) void'(exp_addr_q.pop_front());
    endtask

    // Monitor
    initial begin
        logic [AW-1:0] prev_raddr;
        logic [AW-1:0] a;
        pix_t          e;
        logic [DW+1:0] held;
        bit            stall_prev;
        bit            exp_done;
        prev_raddr = '0;
        stall_prev = 1'b0;
        exp_done   = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_raddr = f1_raddr;
                stall_prev = 1'b0;
                exp_done   = 1'b0;
            end else begin
                if (f1_raddr != prev_raddr) begin
                    if (exp_addr_q.size() == 0) begin
                        check(1'b0, "extra_raddr", int'(f1_raddr), -1);
                    end else begin
                        a = exp_addr_q.pop_front();
                        check(f1_raddr == a, "raddr", int'(f1_raddr), int'(a));
                    end
                    prev_raddr = f1_raddr;
                end
                if (exp_done || frame_done) begin
                    check(frame_done == exp_done, "frame_done", int'(frame_done), int'(exp_done));
                    if (exp_done) check(busy == 1'b0, "busy_at_done", int'(busy), 0);
                end
                exp_done = 1'b0;
                if (stall_prev) begin
                    check(pix_valid && ({pix_data, pix_first, pix_last} == held), "stall_hold",
                          int'({pix_valid, pix_data, pix_first, pix_last}), int'({1'b1, held}));
                end
                if (int'(dut.u_fifo.count_o) > fifo_max) fifo_max = int'(dut.u_fifo.count_o);
                if (pix_valid && pix_ready) begin
                    if (exp_pix_q.size() == 0) begin
                        check(1'b0, "extra_pixel", int'(pix_data), -1);
                    end else begin
                        e = exp_pix_q.pop_front();
                        check((pix_data == e.addr[DW-1:0]) && (pix_first == e.first) &&
                              (pix_last == e.last), "pixel",
                              int'({pix_data, pix_first, pix_last}),
                              int'({e.addr[DW-1:0], e.first, e.last}));
                        if (pix_cnt == 0) first_hs = cyc;
                        last_hs = cyc;
                        pix_cnt++;
                        if (exp_pix_q.size() == 0) exp_done = 1'b1;
                    end
                end
                stall_prev = pix_valid && !pix_ready;
                held       = {pix_data, pix_first, pix_last};
            end
        end
    end

    // pix_ready driver: constant high, or random with one 10-cycle stall around pixel 3000.
    initial begin
        int hold;
        bit hold_used;
        hold      = 0;
        hold_used = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                pix_ready = 1'b1;
            end else begin
                if (!hold_used && pix_cnt >= 3000) begin
                    hold      = 10;
                    hold_used = 1'b1;
                end
                if (hold > 0) begin
                    pix_ready = 1'b0;
                    hold--;
                end else begin
                    pix_ready = ($urandom_range(3, 0) != 0);
                end
            end
        end
    end

    task automatic run_frame(input int mode, input int restart_at, input int reset_at);
        int n;
        bit done;
        bit restarted;
        bit quiet;
        ready_mode = mode;
        @(posedge clk);
        #1;
        pix_cnt  = 0;
        fifo_max = 0;
        check(busy == 1'b0, "idle_before_start", int'(busy), 0);
        build_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check(busy == 1'b1, "busy_after_start", int'(busy), 1);
        if (mode == 0) begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            check(pix_valid == 1'b0, "latency_early", int'(pix_valid), 0);
            @(posedge clk);
            #1;
            check(pix_valid == 1'b1, "latency_3", int'(pix_valid), 1);
        end
        n         = 0;
        done      = 1'b0;
        restarted = 1'b0;
        while (!done && n < 60000) begin
            @(posedge clk);
            #1;
            n++;
            if (restart_at >= 0 && !restarted && pix_cnt >= restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
            if (reset_at >= 0 && pix_cnt >= reset_at) begin
                rst_n = 1'b0;
                exp_pix_q.delete();
                exp_addr_q.delete();
                #1;
                check(pix_valid == 1'b0, "rst_pix_valid", int'(pix_valid), 0);
                check(busy == 1'b0, "rst_busy", int'(busy), 0);
                check(f1_raddr == '0, "rst_raddr", int'(f1_raddr), 0);
                check(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                quiet = 1'b1;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (pix_valid || busy) quiet = 1'b0;
                end
                check(quiet, "quiet_after_reset", int'(!quiet), 0);
                return;
            end
            if (frame_done) done = 1'b1;
        end
        check(done, "frame_timeout", int'(done), 1);
        check(pix_cnt == int'(OUT_W * OUT_H * K * K), "pixel_count", pix_cnt,
              int'(OUT_W * OUT_H * K * K));
        check(exp_addr_q.size() == 0, "addr_left", exp_addr_q.size(), 0);
        check(f1_raddr == AW'(1023), "last_raddr", int'(f1_raddr), 1023);
        check(busy == 1'b0, "busy_at_done_tb", int'(busy), 0);
        @(posedge clk);
        #1;
        check(frame_done == 1'b0, "done_one_cycle", int'(frame_done), 0);
        if (mode == 0) check(last_hs - first_hs == 19599, "throughput", last_hs - first_hs, 19599);
        else check(fifo_max <= int'(FIFO_D), "fifo_bound", fifo_max, int'(FIFO_D));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        #1;
        check(f1_raddr == '0, "reset_raddr", int'(f1_raddr), 0);
        check(pix_valid == 1'b0, "reset_pix_valid", int'(pix_valid), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
        check({pix_data, pix_first, pix_last} == '0, "reset_pix", int'({pix_data, pix_first,
              pix_last}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_frame(0, 500, -1);
        run_frame(1, -1, -1);
        run_frame(0, -1, 1000);
        run_frame(0, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
